spinner_decoder: RTL

SPINNER_DECODER -- requirements
Module: spinner_decoder

---
 rtl/spinner_pkg.sv | 33 +++
 rtl/spinner_decoder_filter.sv | 81 ++++++++
 rtl/spinner_decoder.sv | 91 +++++++++
 3 files changed

// File: rtl/spinner_pkg.sv
// Shared types and constants for the quadrature spinner decoder.
// The phase helpers map an AB value onto its position in the forward ring.
package spinner_pkg;

  localparam int FILTER_LEN_DEF = 4;
  localparam int CNT_W_DEF      = 12;
  localparam logic [1:0] SPIN_IDLE = 2'b11;

  typedef enum logic [1:0] {STEP_NONE, STEP_INC, STEP_DEC, STEP_ERR} step_t;
  typedef enum logic {FLT_STABLE, FLT_CANDIDATE} flt_state_t;

  // Forward ring is 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] quad_phase(input logic [1:0] ab);
    case (ab)
      2'b00:   quad_phase = 2'd0;
      2'b10:   quad_phase = 2'd1;
      2'b11:   quad_phase = 2'd2;
      default: quad_phase = 2'd3;
    endcase
  endfunction

  function automatic step_t quad_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    d = quad_phase(cur) - quad_phase(prev);
    case (d)
      2'd1:    quad_step = STEP_INC;
      2'd3:    quad_step = STEP_DEC;
      2'd2:    quad_step = STEP_ERR;
      default: quad_step = STEP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/spinner_decoder_filter.sv
// Two-flop synchronizer plus STABLE/CANDIDATE debounce FSM.
// Emits a one-cycle commit carrying the old and new filtered AB values.
module quad_glitch_filter
  import spinner_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic       clk_12m,
  input  logic       reset,
  input  logic [1:0] spinner,
  output logic       commit,
  output logic [1:0] old_val,
  output logic [1:0] new_val
);

  localparam logic [3:0] FL = 4'(FILTER_LEN);

  logic [1:0] sync1, sync2, filtered, cand;
  logic [3:0] cnt;
  flt_state_t state;

  always_ff @(posedge clk_12m) begin
    if (!reset) begin
      sync1    <= SPIN_IDLE;
      sync2    <= SPIN_IDLE;
      filtered <= SPIN_IDLE;
      cand     <= SPIN_IDLE;
      state    <= FLT_STABLE;
      cnt      <= '0;
      commit   <= 1'b0;
      old_val  <= SPIN_IDLE;
      new_val  <= SPIN_IDLE;
    end else begin
      sync1  <= spinner;
      sync2  <= sync1;
      commit <= 1'b0;
      case (state)
        FLT_STABLE: begin
          if (sync2 != filtered) begin
            // The first differing cycle already counts as one match.
            if (FILTER_LEN <= 1) begin
              commit   <= 1'b1;
              old_val  <= filtered;
              new_val  <= sync2;
              filtered <= sync2;
            end else begin
              state <= FLT_CANDIDATE;
              cand  <= sync2;
              cnt   <= 4'd1;
            end
          end
        end
        FLT_CANDIDATE: begin
          if (sync2 == cand) begin
            if ((cnt + 4'd1) >= FL) begin
              commit   <= 1'b1;
              old_val  <= filtered;
              new_val  <= cand;
              filtered <= cand;
              state    <= FLT_STABLE;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end else if (sync2 == filtered) begin
            state <= FLT_STABLE;
            cnt   <= '0;
          end else begin
            cand <= sync2;
            cnt  <= 4'd1;
          end
        end
        default: begin
          state <= FLT_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/spinner_decoder.sv
// Quadrature spinner decoder: debounced AB commits are turned into steps,
// a wrapping position, a saturating read-and-clear delta and error tracking.
module spinner_decoder
  import spinner_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk_12m,
  input  logic             reset,
  input  logic [1:0]       spinner,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_delta,
  output logic [7:0]       position,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam logic [CNT_W:0] ONE  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] NEG1 = {(CNT_W+1){1'b1}};

  logic       commit;
  logic [1:0] old_val, new_val;

  quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk_12m (clk_12m),
    .reset   (reset),
    .spinner (spinner),
    .commit  (commit),
    .old_val (old_val),
    .new_val (new_val)
  );

  step_t            kind;
  logic [CNT_W-1:0] acc, acc_step;
  logic [CNT_W:0]   acc_ext;
  logic             ovf;

  // One guard bit; overflow clamps toward the sign of the true sum.
  always_comb begin
    kind    = commit ? quad_step(old_val, new_val) : STEP_NONE;
    acc_ext = {acc[CNT_W-1], acc};
    if (kind == STEP_INC)      acc_ext = acc_ext + ONE;
    else if (kind == STEP_DEC) acc_ext = acc_ext + NEG1;
    ovf = acc_ext[CNT_W] ^ acc_ext[CNT_W-1];
    if (ovf) acc_step = {acc_ext[CNT_W], {(CNT_W-1){~acc_ext[CNT_W]}}};
    else     acc_step = acc_ext[CNT_W-1:0];
  end

  always_ff @(posedge clk_12m) begin
    if (!reset) begin
      acc      <= '0;
      rd_delta <= '0;
      rd_valid <= 1'b0;
      position <= '0;
      step     <= 1'b0;
      dir      <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      step     <= (kind == STEP_INC) || (kind == STEP_DEC);
      rd_valid <= rd_req;
      case (kind)
        STEP_INC: begin
          dir      <= 1'b1;
          position <= position + 8'd1;
        end
        STEP_DEC: begin
          dir      <= 1'b0;
          position <= position - 8'd1;
        end
        STEP_ERR: begin
          err <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
        default: ;
      endcase
      // A read returns the post-step value and clears in the same update.
      if (rd_req) begin
        rd_delta <= acc_step;
        acc      <= '0;
      end else begin
        acc <= acc_step;
      end
    end
  end

endmodule
